// File: rtl/xdma_burst_splitter_pkg.sv
// xdma_burst_splitter_pkg: shared constants and descriptor types for the XDMA write burst splitter.
package xdma_burst_splitter_pkg;
    localparam int unsigned DataWidth = 512;
    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned AxSize    = $clog2(StrbWidth);
    localparam int unsigned AddrWidth = 48;
    localparam int unsigned LenWidth  = 32;
    localparam int unsigned IdWidth   = 4;
    localparam int unsigned MaxBeats  = 256;
    localparam int unsigned PageSize  = 4096;
    localparam int unsigned PageOffW  = $clog2(PageSize);

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    typedef enum logic [1:0] {
        XDMA_REQ_IDX_AW,
        XDMA_REQ_IDX_W,
        XDMA_REQ_IDX_AR
    } xdma_req_idx_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_WAIT_DONE
    } state_e;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [AddrWidth-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
        logic [3:0]           cache;
    } xdma_req_aw_desc_t;

    typedef struct packed {
        logic [8:0] num_beats;
        logic       is_single;
        logic       is_write_data;
    } xdma_req_w_desc_t;
endpackage

// File: rtl/xdma_burst_splitter_if.sv
// xdma_burst_splitter_if: request, descriptor and completion signals of the burst splitter.
interface xdma_burst_splitter_if;
    import xdma_burst_splitter_pkg::*;
    logic                 req_valid_i;
    logic                 req_ready_o;
    logic [IdWidth-1:0]   req_id_i;
    logic [AddrWidth-1:0] req_addr_i;
    logic [LenWidth-1:0]  req_len_i;
    logic                 req_is_write_data_i;
    logic                 out_valid_o;
    logic                 out_ready_i;
    xdma_req_aw_desc_t    out_aw_desc_o;
    xdma_req_w_desc_t     out_w_desc_o;
    logic                 wr_done_i;
    logic                 busy_o;
    logic [15:0]          burst_cnt_o;

    modport slave (
        input  req_valid_i, req_id_i, req_addr_i, req_len_i, req_is_write_data_i,
        input  out_ready_i, wr_done_i,
        output req_ready_o, out_valid_o, out_aw_desc_o, out_w_desc_o, busy_o, burst_cnt_o
    );

    modport master (
        output req_valid_i, req_id_i, req_addr_i, req_len_i, req_is_write_data_i,
        output out_ready_i, wr_done_i,
        input  req_ready_o, out_valid_o, out_aw_desc_o, out_w_desc_o, busy_o, burst_cnt_o
    );
endinterface

// File: rtl/xdma_burst_splitter_calc.sv
// xdma_burst_splitter_calc: beats of the next burst = min(remaining, MaxBeats, beats left in page).
module xdma_burst_splitter_calc
    import xdma_burst_splitter_pkg::*;
(
    input  logic [LenWidth-1:0] i_remaining,
    input  logic [PageOffW-1:0] i_page_off,
    output logic [8:0]          o_beats
);
    logic [PageOffW:0]   w_page_bytes;
    logic [LenWidth-1:0] w_to_page;
    logic [LenWidth-1:0] w_lim;

    assign w_page_bytes = (PageOffW+1)'(PageSize) - {1'b0, i_page_off};
    assign w_to_page    = LenWidth'(w_page_bytes >> AxSize);
    assign w_lim        = (w_to_page < LenWidth'(MaxBeats)) ? w_to_page : LenWidth'(MaxBeats);
    assign o_beats      = 9'((i_remaining < w_lim) ? i_remaining : w_lim);
endmodule

// File: rtl/xdma_burst_splitter.sv
// xdma_burst_splitter: splits one XDMA write request into page-safe AXI AW/W descriptor pairs.
module xdma_burst_splitter
    import xdma_burst_splitter_pkg::*;
(
    input logic                  clk_i,
    input logic                  rst_ni,
    xdma_burst_splitter_if.slave bus
);
    state_e               r_state;
    state_e               w_state_nxt;
    logic [IdWidth-1:0]   r_id;
    logic [AddrWidth-1:0] r_addr;
    logic [LenWidth-1:0]  r_rem;
    logic                 r_wd;
    logic [15:0]          r_cnt;
    logic                 r_done_seen;
    logic [8:0]           w_beats;
    logic                 w_accept;
    logic                 w_fire;
    logic                 w_last;

    xdma_burst_splitter_calc u_calc (
        .i_remaining (r_rem),
        .i_page_off  (r_addr[PageOffW-1:0]),
        .o_beats     (w_beats)
    );

    assign w_accept = bus.req_valid_i && r_state == ST_IDLE;
    assign w_fire   = bus.out_valid_o && bus.out_ready_i;
    assign w_last   = r_rem == LenWidth'(w_beats);

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:      if (bus.req_valid_i && bus.req_len_i != '0) w_state_nxt = ST_BUSY;
            ST_BUSY:      if (w_fire && w_last) w_state_nxt = ST_WAIT_DONE;
            ST_WAIT_DONE: if (r_done_seen || bus.wr_done_i) w_state_nxt = ST_IDLE;
            default:      w_state_nxt = ST_IDLE;
        endcase
    end

    // Descriptors come purely from flops and read as zero outside BUSY
    assign bus.req_ready_o   = r_state == ST_IDLE;
    assign bus.busy_o        = r_state != ST_IDLE;
    assign bus.out_valid_o   = r_state == ST_BUSY;
    assign bus.burst_cnt_o   = r_cnt;
    assign bus.out_aw_desc_o = bus.out_valid_o ? xdma_req_aw_desc_t'{id: r_id, addr: r_addr,
        len: 8'(w_beats - 9'd1), size: 3'(AxSize), burst: AXI_BURST_INCR, cache: 4'd0} : '0;
    assign bus.out_w_desc_o  = bus.out_valid_o ? xdma_req_w_desc_t'{num_beats: w_beats,
        is_single: w_beats == 9'd1, is_write_data: r_wd} : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= ST_IDLE;
            r_id        <= '0;
            r_addr      <= '0;
            r_rem       <= '0;
            r_wd        <= 1'b0;
            r_cnt       <= '0;
            r_done_seen <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_done_seen <= (w_state_nxt == ST_IDLE) ? 1'b0 : r_done_seen | (bus.wr_done_i && r_state != ST_IDLE);
            if (w_accept) begin
                r_id   <= bus.req_id_i;
                r_addr <= bus.req_addr_i;
                r_rem  <= bus.req_len_i;
                r_wd   <= bus.req_is_write_data_i;
                r_cnt  <= '0;
            end else if (w_fire) begin
                r_addr <= r_addr + (AddrWidth'(w_beats) << AxSize);
                r_rem  <= r_rem - LenWidth'(w_beats);
                r_cnt  <= r_cnt + {15'd0, r_cnt != 16'hFFFF};
            end
        end
    end

    assert property (@(posedge clk_i) disable iff (!rst_ni) w_accept |-> bus.req_addr_i[AxSize-1:0] == '0);
endmodule
